// File: rtl/sample_serializer.sv
// Mixes the per-voice subsample stream into one mono sample, scales and
// saturates it, and streams it left-justified (MSB first) to a stereo DAC
// with the same word in both slots. Sticky flags report stream faults.
module sample_serializer #(
  parameter int VOICES       = 16,
  parameter int ACC_WIDTH    = 20,
  parameter int VOLUME_SHIFT = 4,
  parameter int BCLK_HALF    = 4
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic signed [15:0] i_Subsample,
  input  logic               i_SubsampleReady,
  input  logic               i_SampleReady,
  output logic signed [15:0] o_MixedSample,
  output logic               o_MixedValid,
  output logic               o_BitClock,
  output logic               o_LeftRightClock,
  output logic               o_SerialData,
  output logic               o_Overrun,
  output logic               o_Underrun,
  output logic               o_CountError
);

  // One spare bit so an over-long sample never wraps back to a "correct" count.
  localparam int CNT_W = $clog2(VOICES) + 1;
  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(32767);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-32768);

  // Volume scaling is a plain arithmetic shift (truncates toward -inf).
  function automatic logic signed [ACC_WIDTH-1:0] scale(
    input logic signed [ACC_WIDTH-1:0] v
  );
    return v >>> VOLUME_SHIFT;
  endfunction

  // Clamp the scaled sum into the 16-bit signed output range.
  function automatic logic signed [15:0] saturate(
    input logic signed [ACC_WIDTH-1:0] v
  );
    if (v > SAT_MAX) begin
      return 16'sh7FFF;
    end else if (v < SAT_MIN) begin
      return 16'sh8000;
    end
    return v[15:0];
  endfunction

  logic signed [ACC_WIDTH-1:0] acc_p0;
  logic signed [ACC_WIDTH-1:0] sub_ext_p0;
  logic signed [ACC_WIDTH-1:0] sum_p0;
  logic signed [15:0]          mixed_p0;
  logic [CNT_W-1:0]            voice_cnt;
  logic                        close_p0;

  logic signed [15:0]          mixed_p1;
  logic                        vld_p1;

  logic                        pending;
  logic [15:0]                 pend_word;
  logic                        overrun;

  logic [DIV_W-1:0]            div_cnt;
  logic                        div_tc;
  logic                        bclk;
  logic                        bclk_fall;
  logic [4:0]                  bit_idx;
  logic [4:0]                  bit_next;
  logic                        frame_load;
  logic [15:0]                 frame_word;
  logic [15:0]                 tx_word;
  logic                        lrclk;
  logic                        sdata;
  logic                        underrun;
  logic                        count_err;

  // ---- stage p0: accumulate the incoming subsample ----
  assign sub_ext_p0 = {{(ACC_WIDTH-16){i_Subsample[15]}}, i_Subsample};
  assign sum_p0     = acc_p0 + sub_ext_p0;
  assign close_p0   = i_SubsampleReady & i_SampleReady;
  assign mixed_p0   = saturate(scale(sum_p0));

  // Running sum and voice count; both clear on the closing subsample so the
  // next sample period can start on the very next cycle.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      acc_p0    <= '0;
      voice_cnt <= '0;
    end else if (i_SubsampleReady) begin
      if (i_SampleReady) begin
        acc_p0    <= '0;
        voice_cnt <= '0;
      end else begin
        acc_p0    <= sum_p0;
        voice_cnt <= (voice_cnt == '1) ? voice_cnt : voice_cnt + 1'b1;
      end
    end
  end

  // Sticky flag: a sample closed with the wrong number of voices.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      count_err <= 1'b0;
    end else if (close_p0 && (voice_cnt != CNT_W'(VOICES - 1))) begin
      count_err <= 1'b1;
    end
  end

  // ---- stage p1: registered mixed sample ----
  // Parallel debug output of the mixed sample with a one-cycle valid pulse.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      mixed_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= close_p0;
      if (close_p0) begin
        mixed_p1 <= mixed_p0;
      end
    end
  end

  // Bit-clock divider: toggles the bit clock every BCLK_HALF cycles.
  assign div_tc    = (div_cnt == DIV_W'(BCLK_HALF - 1));
  assign bclk_fall = div_tc & bclk;
  assign bit_next  = bit_idx + 5'd1;
  assign frame_load = bclk_fall & (bit_next == 5'd0);
  // A frame starting now takes the pending word if there is one; a sample
  // arriving on this same edge only becomes the next pending word.
  assign frame_word = (frame_load && pending) ? pend_word : tx_word;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (div_tc) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Single-entry holding buffer between the mixer and the serializer.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      pending   <= 1'b0;
      pend_word <= '0;
      overrun   <= 1'b0;
    end else if (close_p0) begin
      pend_word <= mixed_p0;
      pending   <= 1'b1;
      if (pending && !frame_load) begin
        overrun <= 1'b1;
      end
    end else if (frame_load && pending) begin
      pending <= 1'b0;
    end
  end

  // Serial shifter: all DAC lines change on bit-clock falling edges only.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      bit_idx  <= 5'd31;
      tx_word  <= '0;
      lrclk    <= 1'b0;
      sdata    <= 1'b0;
      underrun <= 1'b0;
    end else if (bclk_fall) begin
      bit_idx <= bit_next;
      lrclk   <= bit_next[4];
      sdata   <= frame_word[4'd15 - bit_next[3:0]];
      if (frame_load) begin
        tx_word <= frame_word;
        if (!pending) begin
          underrun <= 1'b1;
        end
      end
    end
  end

  assign o_MixedSample    = mixed_p1;
  assign o_MixedValid     = vld_p1;
  assign o_BitClock       = bclk;
  assign o_LeftRightClock = lrclk;
  assign o_SerialData     = sdata;
  assign o_Overrun        = overrun;
  assign o_Underrun       = underrun;
  assign o_CountError     = count_err;

endmodule
